mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store engine between the EX/MEM pipeline register and the MEM/WB register.
- Takes the decoded memory op, address and store data.
- Runs a req/ack transaction on the data bus and stalls the pipeline while it waits.
- Sign/zero-extends load data and detects address exceptions (AdEL/AdES) and bus timeouts (DBE).
- Presents the final MEM_WD/MEM_A3 to MEM/WB.

Parameters:
- DM_LIMIT, 32'h0000_3000, first byte address outside data memory; any access at or above it raises an exception.
- TIMEOUT, 16, maximum number of cycles spent in BUSY without m_ack before a DBE is raised.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  exception/interrupt flush request (the same signal that flushes MEM/WB).
- in_valid  in  1  the EX/MEM slot holds a real instruction.
- mem_op  in  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB.
- mem_addr  in  32  byte address, computed in EX.
- mem_wdata  in  32  store data; low byte/half is used for SB/SH.
- in_WD  in  32  non-load writeback value, passed through.
- in_A3  in  5  destination register.
- m_req  out  1  bus request; held until m_ack.
- m_we  out  1  store when 1.
- m_addr  out  32  word-aligned address {mem_addr[31:2],2'b00}.
- m_byteen  out  4  byte enables.
- m_wdata  out  32  store lane data, replicated to every lane.
- m_rdata  in  32  read word.
- m_ack  in  1  one-cycle completion strobe.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- exc  out  5  0 none, 4 AdEL, 5 AdES, 7 DBE.
- MEM_WD  out  32  writeback data to MEM/WB.
- MEM_A3  out  5  destination to MEM/WB; forced to 0 on exception.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - m_req=0, m_we=0, m_byteen=0, m_addr=0, m_wdata=0.
  - load_q=0, timeout counter=0, pend_flush=0.
  - stall=0, exc=0.
- Address check, combinational in IDLE:
  - LW/SW with addr[1:0]!=0 is misaligned.
  - LH/LHU/SH with addr[0]!=0 is misaligned.
  - Any op with addr>=DM_LIMIT is out of range.
  - Loads report exc=4, stores report exc=5.
  - No bus access is made; MEM_A3=0 and stall=0 the same cycle.
- start = in_valid & op!=NONE & no address exception & !req.
- IDLE:
  - stall = start.
  - On start, next state is BUSY.
  - Register m_req=1, m_we, m_addr, m_byteen and m_wdata on that edge.
  - Clear the timeout counter.
  - Otherwise stay in IDLE; MEM_WD=in_WD, MEM_A3=in_A3.
- BUSY:
  - stall=1; bus outputs held stable.
  - The counter increments every cycle.
  - On m_ack: capture the extended load into load_q, drop m_req/m_we/m_byteen, go to DONE.
  - If the counter reaches TIMEOUT-1 without ack: drop m_req, go to DONE with DBE flagged.
- DONE (exactly one cycle):
  - stall=0, so EX/MEM advances at the end of this cycle.
  - MEM_WD = load_q for loads, in_WD for stores.
  - exc=7 if DBE, and MEM_A3 is forced to 0.
  - Next state is IDLE.
- Byte enables:
  - SW: 4'b1111.
  - SH: 4'b0011 << (2*addr[1]).
  - SB: 4'b0001 << addr[1:0].
  - All loads: 4'b0000.
- Load extension:
  - Select the byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- Flush:
  - req in IDLE blocks start.
  - req in BUSY cannot abort the transaction, because a store may already be committed. It sets pend_flush instead.
  - When pend_flush is set, DONE outputs MEM_A3=0 and exc=0, and pend_flush is cleared.
- m_ack is ignored outside BUSY.
- A back-to-back memory op re-enters BUSY from IDLE, so the minimum latency is 3 cycles per access.

Decomposition:
- Shared package, used by the decoder as well:
  - mem_op encodings.
  - Exception codes EXC_NONE/ADEL/ADES/DBE.
  - FSM state constants IDLE/BUSY/DONE.
- Sub-module load_ext (combinational): addr[1:0] plus op plus rdata gives the extended word.

Test Plan:
- LW addr 0x10, m_ack 2 cycles after m_req, m_rdata 0xDEADBEEF -> MEM_WD=0xDEADBEEF in DONE, stall high 3 cycles, MEM_A3=in_A3.
- LB addr 0x13, rdata 0x80FF_0000 -> MEM_WD=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x12 -> 0xFFFF80FF.
- SH addr 0x22, wdata 0x1234ABCD -> m_byteen=4'b1100, m_addr=0x20, m_wdata=0xABCDABCD, m_we=1.
- LW addr 0x6 -> exc=4, m_req never asserted, stall=0, MEM_A3=0; SW addr 0x3000 -> exc=5.
- Load with no m_ack -> m_req drops after 16 BUSY cycles, exc=7, MEM_A3=0; late m_ack ignored.
- req pulsed mid-BUSY on SW -> store still completes with ack, DONE gives MEM_A3=0, exc=0. Separately, reset asserted mid-BUSY -> m_req=0 and state=IDLE immediately.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store engine and the decoder:
// memory op encodings, exception codes and FSM states.
package mem_access_unit_pkg;

    localparam logic [31:0] DM_LIMIT_DEFAULT = 32'h0000_3000;
    localparam int          TIMEOUT_DEFAULT  = 16;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } mem_op_e;

    typedef enum logic [4:0] {
        EXC_NONE = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_DBE  = 5'd7
    } exc_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [3:0]  op,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'd0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: runs one req/ack bus transaction per memory op,
// stalls the pipeline meanwhile and reports AdEL/AdES/DBE exceptions.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter logic [31:0] DM_LIMIT = DM_LIMIT_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        in_valid,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] in_WD,
    input  logic [4:0]  in_A3,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_byteen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        stall,
    output logic [4:0]  exc,
    output logic [31:0] MEM_WD,
    output logic [4:0]  MEM_A3
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_e             state;
    state_e             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        load_q;
    logic               pend_flush;
    logic               dbe_q;

    logic               op_load;
    logic               op_store;
    logic               misaligned;
    logic               out_range;
    logic               addr_exc;
    logic               start;
    logic               timeout_hit;
    logic [3:0]         byteen_c;
    logic [31:0]        wdata_c;
    logic [31:0]        ext_data;

    assign op_load     = is_load(mem_op);
    assign op_store    = is_store(mem_op);
    assign out_range   = mem_addr >= DM_LIMIT;
    assign addr_exc    = in_valid && (op_load || op_store) && (misaligned || out_range);
    assign start       = in_valid && (op_load || op_store) && !addr_exc && !req;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        misaligned = 1'b0;
        byteen_c   = 4'b0000;
        wdata_c    = 32'd0;
        case (mem_op)
            OP_LW:  misaligned = (mem_addr[1:0] != 2'b00);
            OP_LH,
            OP_LHU: misaligned = mem_addr[0];
            OP_SW: begin
                misaligned = (mem_addr[1:0] != 2'b00);
                byteen_c   = 4'b1111;
                wdata_c    = mem_wdata;
            end
            OP_SH: begin
                misaligned = mem_addr[0];
                byteen_c   = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_c    = {2{mem_wdata[15:0]}};
            end
            OP_SB: begin
                byteen_c   = 4'b0001 << mem_addr[1:0];
                wdata_c    = {4{mem_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    load_ext u_load_ext (
        .addr  (mem_addr[1:0]),
        .op    (mem_op),
        .rdata (m_rdata),
        .data  (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        exc        = EXC_NONE;
        MEM_WD     = in_WD;
        MEM_A3     = in_A3;
        case (state)
            IDLE: begin
                stall = start;
                if (start) next_state = BUSY;
                if (addr_exc) begin
                    exc    = op_store ? EXC_ADES : EXC_ADEL;
                    MEM_A3 = 5'd0;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (m_ack || timeout_hit) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
                if (op_load) MEM_WD = load_q;
                // A flush that arrived mid-transaction silences both the
                // writeback and any bus error of this instruction.
                if (pend_flush) begin
                    MEM_A3 = 5'd0;
                end else if (dbe_q) begin
                    exc    = EXC_DBE;
                    MEM_A3 = 5'd0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 32'd0;
            m_byteen   <= 4'b0000;
            m_wdata    <= 32'd0;
            cnt        <= '0;
            load_q     <= 32'd0;
            pend_flush <= 1'b0;
            dbe_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_req    <= 1'b1;
                        m_we     <= op_store;
                        m_addr   <= {mem_addr[31:2], 2'b00};
                        m_byteen <= byteen_c;
                        m_wdata  <= wdata_c;
                        cnt      <= '0;
                        dbe_q    <= 1'b0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (req) pend_flush <= 1'b1;
                    if (m_ack) begin
                        load_q   <= ext_data;
                        m_req    <= 1'b0;
                        m_we     <= 1'b0;
                        m_byteen <= 4'b0000;
                    end else if (timeout_hit) begin
                        m_req    <= 1'b0;
                        m_we     <= 1'b0;
                        m_byteen <= 4'b0000;
                        dbe_q    <= 1'b1;
                    end
                end
                DONE: begin
                    pend_flush <= 1'b0;
                    dbe_q      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
